// File: rtl/bus_arbiter2.sv
// -----------------------------------------------------------------------------
// bus_arbiter2
//
// Round-robin arbiter and controller for a 2:1 shared-bus multiplexer. Two
// requesters compete for one DATA_W-bit bus. A registered state machine owns
// the grant and the mux select. A burst counter lets an owner keep the bus for
// at most MAX_BURST consecutive cycles while the other side is waiting.
//
// Ports
//   clk        system clock, rising-edge active
//   reset      asynchronous active-high reset
//   req0/req1  bus requests, held high for the whole transfer
//   in0/in1    requester data, kept stable while granted
//   gnt0/gnt1  registered grants, mutually exclusive
//   sel        registered mux select (0 = in0, 1 = in1)
//   bus_out    granted input, or 0 when no one owns the bus
//   bus_valid  gnt0 | gnt1
// -----------------------------------------------------------------------------
module bus_arbiter2 #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4      // legal range 2..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_valid
);

    localparam int               CNT_W   = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             last_served_reg, last_served_next;
    logic             at_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            last_served_reg <= 1'b1;   // requester 0 wins the first tie
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            last_served_reg <= last_served_next;
        end
    end

    // The owner has used up its burst once the counter reaches MAX_BURST-1.
    assign at_limit = (count_reg == CNT_MAX);

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        last_served_next = last_served_reg;

        case (state_reg)
            IDLE: begin
                if (req0 && req1)
                    state_next = last_served_reg ? OWN0 : OWN1;
                else if (req0)
                    state_next = OWN0;
                else if (req1)
                    state_next = OWN1;
            end
            OWN0: begin
                // Dropping the request hands over directly, with no idle bubble.
                if (!req0)
                    state_next = req1 ? OWN1 : IDLE;
                else if (req1 && at_limit)
                    state_next = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_next = req0 ? OWN0 : IDLE;
                else if (req0 && at_limit)
                    state_next = OWN0;
            end
            default: state_next = IDLE;
        endcase

        // The counter restarts on any state change. Otherwise it counts owned
        // cycles and saturates. A late contender therefore sees an immediate
        // preemption if the owner has already run its full burst.
        if (state_next != state_reg)
            count_next = '0;
        else if (state_reg != IDLE && !at_limit)
            count_next = count_reg + CNT_W'(1);

        if (state_next == OWN0 && state_reg != OWN0)
            last_served_next = 1'b0;
        else if (state_next == OWN1 && state_reg != OWN1)
            last_served_next = 1'b1;
    end

    assign gnt0      = (state_reg == OWN0);
    assign gnt1      = (state_reg == OWN1);
    assign sel       = (state_reg == OWN1);
    assign bus_valid = gnt0 | gnt1;

    // AND-OR mux. The grants are one-hot or zero, so bus_out is 0 when idle.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bus_mux
            assign bus_out[gi] = (gnt0 & in0[gi]) | (gnt1 & in1[gi]);
        end
    endgenerate

endmodule

// File: tb/tb_bus_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter2
//
// Self-checking bench for bus_arbiter2 (DATA_W=16, MAX_BURST=4). It runs three
// phases:
//   - a directed vector table, one cycle per record;
//   - hand-written sequences: a late contender after saturation, and reset
//     asserted mid-grant;
//   - randomized requests checked against an ownership/run-length model, with
//     per-cycle invariants.
// -----------------------------------------------------------------------------
module tb_bus_arbiter2;

    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1;
    logic [DATA_W-1:0] in0, in1;
    logic              gnt0, gnt1, sel, bus_valid;
    logic [DATA_W-1:0] bus_out;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter2 #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .in0      (in0),
        .in1      (in1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .sel      (sel),
        .bus_out  (bus_out),
        .bus_valid(bus_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        r0;
        logic        r1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        g0;
        logic        g1;
        logic        s;
        logic [15:0] bo;
        logic        v;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic r0, input logic r1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic g0, input logic g1, input logic s,
                       input logic [15:0] bo, input logic v);
        vec_t t;
        t = '{rst, r0, r1, d0, d1, g0, g1, s, bo, v};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic g0, input logic g1, input logic s,
                           input logic [15:0] bo, input logic v);
        chk({tag, ".gnt0"},      32'(gnt0),      32'(g0));
        chk({tag, ".gnt1"},      32'(gnt1),      32'(g1));
        chk({tag, ".sel"},       32'(sel),       32'(s));
        chk({tag, ".bus_out"},   32'(bus_out),   32'(bo));
        chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(v));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Reference model. It tracks who owns the bus (-1 = nobody), how many
    // cycles the current owner has held it, and who was served last.
    int m_owner, m_held, m_last;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 1;
    endtask

    task automatic model_edge(input logic r0, input logic r1);
        int  nxt;
        bit  want[2];
        want[0] = r0;
        want[1] = r1;
        if (m_owner < 0) begin
            if (r0 && r1)  nxt = 1 - m_last;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
        end else if (!want[m_owner]) begin
            nxt = want[1 - m_owner] ? 1 - m_owner : -1;
        end else if (want[1 - m_owner] && m_held >= MAX_BURST) begin
            nxt = 1 - m_owner;
        end else begin
            nxt = m_owner;
        end
        if (nxt != m_owner) begin
            m_held = (nxt < 0) ? 0 : 1;
            if (nxt >= 0) m_last = nxt;
        end else if (m_owner >= 0) begin
            m_held++;
        end
        m_owner = nxt;
    endtask

    initial begin
        logic [15:0] exp_bo;
        int          streak0, streak1;

        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        in0   = '0;
        in1   = '0;

        // ---- Directed vector table: inputs applied, edge, outputs checked ----
        add(1, 0, 0, 16'h0003, 16'h000C, 0, 0, 0, 16'h0000, 0); // reset
        add(0, 0, 0, 16'h0003, 16'h000C, 0, 0, 0, 16'h0000, 0); // idle
        add(0, 1, 0, 16'h0003, 16'h000C, 1, 0, 0, 16'h0003, 1); // single request
        add(0, 0, 0, 16'h0003, 16'h000C, 0, 0, 0, 16'h0000, 0); // drop -> idle
        add(1, 0, 0, 16'h0003, 16'h000C, 0, 0, 0, 16'h0000, 0); // reset again
        add(0, 1, 1, 16'h0003, 16'h000C, 1, 0, 0, 16'h0003, 1); // tie -> req0 wins
        add(0, 1, 1, 16'h0003, 16'h000C, 1, 0, 0, 16'h0003, 1);
        add(0, 1, 1, 16'h0003, 16'h000C, 1, 0, 0, 16'h0003, 1);
        add(0, 1, 1, 16'h0003, 16'h000C, 1, 0, 0, 16'h0003, 1); // 4th cycle
        add(0, 1, 1, 16'h0003, 16'h000C, 0, 1, 1, 16'h000C, 1); // preempt to req1
        add(0, 1, 1, 16'h0003, 16'h000C, 0, 1, 1, 16'h000C, 1);
        add(0, 1, 1, 16'h0003, 16'h000C, 0, 1, 1, 16'h000C, 1);
        add(0, 1, 1, 16'h0003, 16'h000C, 0, 1, 1, 16'h000C, 1);
        add(0, 1, 1, 16'h0003, 16'h000C, 1, 0, 0, 16'h0003, 1); // back to req0
        add(0, 0, 1, 16'h0003, 16'h000C, 0, 1, 1, 16'h000C, 1); // direct handover
        add(0, 0, 0, 16'h0003, 16'h000C, 0, 0, 0, 16'h0000, 0);
        add(0, 1, 0, 16'h0003, 16'h000C, 1, 0, 0, 16'h0003, 1);
        add(0, 0, 1, 16'hA5A5, 16'h5A5A, 0, 1, 1, 16'h5A5A, 1); // handover, new data
        add(0, 1, 1, 16'hA5A5, 16'h5A5A, 0, 1, 1, 16'h5A5A, 1); // burst not used up
        add(0, 1, 0, 16'hA5A5, 16'h5A5A, 1, 0, 0, 16'hA5A5, 1); // owner drops

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            req0  = vecs[i].r0;
            req1  = vecs[i].r1;
            in0   = vecs[i].d0;
            in1   = vecs[i].d1;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].s,
                    vecs[i].bo, vecs[i].v);
            $display("vec%0d rst=%0b req=%0b%0b -> gnt=%0b%0b sel=%0b bus=%h valid=%0b",
                     i, vecs[i].rst, vecs[i].r1, vecs[i].r0, gnt1, gnt0, sel, bus_out, bus_valid);
        end

        // ---- Late contender after saturation ----
        in0 = 16'h1111;
        in1 = 16'h2222;
        pulse_reset();
        req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("late.solo%0d.gnt0", i), 32'(gnt0), 32'd1);
        end
        req1 = 1'b1;
        step();
        chk_all("late.preempt", 0, 1, 1, 16'h2222, 1);
        $display("late contender: gnt=%0b%0b bus=%h", gnt1, gnt0, bus_out);

        // ---- Reset mid-grant takes effect without a clock edge ----
        pulse_reset();
        req1 = 1'b1;
        step();
        chk_all("midrst.own1", 0, 1, 1, 16'h2222, 1);
        req0 = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk_all("midrst.async", 0, 0, 0, 16'h0000, 0);
        step();
        reset = 1'b0;
        step();
        chk_all("midrst.after", 1, 0, 0, 16'h1111, 1);
        $display("reset mid-grant: gnt=%0b%0b bus=%h", gnt1, gnt0, bus_out);

        // ---- Randomized run against the model, with invariants ----
        pulse_reset();
        model_reset();
        streak0 = 0;
        streak1 = 0;
        for (int c = 0; c < 1000; c++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            in0  = 16'($urandom);
            in1  = 16'($urandom);
            #1;
            // Count cycles an owner keeps the bus while the other side is waiting.
            streak0 = (gnt0 && req1) ? streak0 + 1 : 0;
            streak1 = (gnt1 && req0) ? streak1 + 1 : 0;
            chk("rand.burst0", 32'(streak0 <= MAX_BURST), 32'd1);
            chk("rand.burst1", 32'(streak1 <= MAX_BURST), 32'd1);
            step();
            model_edge(req0, req1);
            exp_bo = (m_owner == 0) ? in0 : (m_owner == 1) ? in1 : 16'h0000;
            chk_all($sformatf("rand%0d", c), m_owner == 0, m_owner == 1, m_owner == 1,
                    exp_bo, m_owner >= 0);
            chk("rand.exclusive", 32'(gnt0 & gnt1), 32'd0);
            if (!bus_valid) chk("rand.idle_zero", 32'(bus_out), 32'd0);
        end
        $display("random run: 1000 cycles done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
